// File: rtl/ahb_master.sv
// rtl/ahb_master.sv - single-channel pipelined AHB-Lite master (word, NONSEQ-only)
// Optional: define AHB_MASTER_RDATA_REG_EN to register o_rd_valid/o_rd_data.
module ahb_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk_ahb,
   input  logic                  i_rstn_ahb,
   output logic [ADDR_WIDTH-1:0] HADDR,
   output logic [DATA_WIDTH-1:0] HWDATA,
   output logic                  HWRITE,
   output logic [2:0]            HSIZE,
   output logic [1:0]            HTRANS,
   output logic                  HMASTLOCK,
   input  logic                  HREADY,
   input  logic [DATA_WIDTH-1:0] HRDATA,
   input  logic                  HRESP,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_rd0_wr1,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic                  o_rd_valid,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   logic                  dp_valid;
   logic                  dp_write;
   logic [DATA_WIDTH-1:0] dp_wdata;
   logic                  err_q;
   logic                  accept;
   logic                  cancel;
   logic                  rd_done;
   logic [DATA_WIDTH-1:0] rd_data_c;

   // First ERROR cycle: the pending address phase must be withdrawn.
   assign cancel = dp_valid & HRESP & ~HREADY;
   assign accept = i_valid & HREADY;

   always_comb begin
      HADDR  = '0;
      HWRITE = 1'b0;
      HTRANS = HTRANS_IDLE;
      if (i_rstn_ahb && i_valid) begin
         HADDR  = i_addr;
         HWRITE = i_rd0_wr1;
         if (!cancel) begin
            HTRANS = HTRANS_NONSEQ;
         end
      end
   end

   assign HSIZE     = 3'b010;
   assign HMASTLOCK = 1'b0;
   assign HWDATA    = dp_wdata;
   assign o_ready   = HREADY & i_rstn_ahb;

   // Errored reads still complete, but with zero data.
   assign rd_done   = dp_valid & ~dp_write & HREADY;
   assign rd_data_c = (rd_done && !(HRESP || err_q)) ? HRDATA : '0;

   always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
      if (!i_rstn_ahb) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_wdata <= '0;
         err_q    <= 1'b0;
      end else begin
         if (HREADY) begin
            dp_valid <= i_valid;
            if (accept) begin
               dp_write <= i_rd0_wr1;
               if (i_rd0_wr1) begin
                  dp_wdata <= i_wr_data;
               end
            end
         end
         if (cancel) begin
            err_q <= 1'b1;
         end else if (HREADY) begin
            err_q <= 1'b0;
         end
      end
   end

`ifdef AHB_MASTER_RDATA_REG_EN
   always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
      if (!i_rstn_ahb) begin
         o_rd_valid <= 1'b0;
         o_rd_data  <= '0;
      end else begin
         o_rd_valid <= rd_done;
         o_rd_data  <= rd_data_c;
      end
   end
`else
   assign o_rd_valid = rd_done;
   assign o_rd_data  = rd_data_c;
`endif

endmodule

// File: tb/tb_ahb_master.sv
// tb/tb_ahb_master.sv - self-checking bench for ahb_master with a transaction-queue model
module tb_ahb_master;

   logic        clk;
   logic        rstn;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   logic        hmastlock;
   logic        hready;
   logic [31:0] hrdata;
   logic        hresp;
   logic [31:0] addr;
   logic        wr;
   logic [31:0] wdata;
   logic        valid;
   logic        ready;
   logic        rd_valid;
   logic [31:0] rd_data;

   int checks = 0;
   int errors = 0;

`ifdef AHB_MASTER_RDATA_REG_EN
   localparam int RL = 1;
`else
   localparam int RL = 0;
`endif

   ahb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .i_clk_ahb (clk),
      .i_rstn_ahb(rstn),
      .HADDR     (haddr),
      .HWDATA    (hwdata),
      .HWRITE    (hwrite),
      .HSIZE     (hsize),
      .HTRANS    (htrans),
      .HMASTLOCK (hmastlock),
      .HREADY    (hready),
      .HRDATA    (hrdata),
      .HRESP     (hresp),
      .i_addr    (addr),
      .i_rd0_wr1 (wr),
      .i_wr_data (wdata),
      .i_valid   (valid),
      .o_ready   (ready),
      .o_rd_valid(rd_valid),
      .o_rd_data (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: transfers sitting in their data phase, plus last write data.
   typedef struct {
      logic        write;
      logic [31:0] wdata;
   } xfer_t;

   xfer_t       dq[$];
   logic [31:0] m_hwdata;
   logic        m_prev_rv;
   logic [31:0] m_prev_rd;
   logic        c_rv;
   logic [31:0] c_rd;
   logic        e_rv;
   logic [31:0] e_rd;
   logic [31:0] e_haddr;
   logic [1:0]  e_trans;
   logic        e_ready;
   logic        e_hwrite;

   task automatic model_clear();
      dq.delete();
      m_hwdata  = '0;
      m_prev_rv = 1'b0;
      m_prev_rd = '0;
   endtask

   task automatic eval();
      e_trans  = (rstn && valid && !(dq.size() > 0 && hresp && !hready)) ? 2'b10 : 2'b00;
      e_haddr  = (rstn && valid) ? addr : 32'h0;
      e_hwrite = rstn && valid && wr;
      e_ready  = rstn && hready;
      c_rv     = rstn && dq.size() > 0 && !dq[0].write && hready;
      c_rd     = (c_rv && !hresp) ? hrdata : 32'h0;
      if (RL == 1) begin
         e_rv = rstn && m_prev_rv;
         e_rd = rstn ? m_prev_rd : 32'h0;
      end else begin
         e_rv = c_rv;
         e_rd = c_rd;
      end
   endtask

   task automatic tick();
      eval();
      @(posedge clk);
      if (!rstn) begin
         model_clear();
      end else begin
         m_prev_rv = c_rv;
         m_prev_rd = c_rd;
         if (hready) begin
            if (dq.size() > 0) void'(dq.pop_front());
            if (valid) begin
               dq.push_back('{write: wr, wdata: wdata});
               if (wr) m_hwdata = wdata;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      rstn = 1'b0; valid = 1'b1; addr = 32'h100; wr = 1'b1; wdata = 32'h1111_1111;
      hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
      model_clear();
      #3;
      checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL reset_htrans got %h exp 0", htrans); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
      checks++; if (haddr !== 32'h0 || hwrite !== 1'b0) begin errors++; $display("FAIL reset_addr got %h/%b exp 0/0", haddr, hwrite); end
      checks++; if (hwdata !== 32'h0 || rd_valid !== 1'b0 || rd_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h/%b/%h exp 0/0/0", hwdata, rd_valid, rd_data); end
      checks++; if (hsize !== 3'b010 || hmastlock !== 1'b0) begin errors++; $display("FAIL const_outs got %h/%b exp 2/0", hsize, hmastlock); end
      tick();
      rstn = 1'b1;
      #3;
      checks++; if (htrans !== 2'b10 || haddr !== 32'h100) begin errors++; $display("FAIL release_issue got %h/%h exp 2/100", htrans, haddr); end
      tick();
      valid = 1'b0;
      #3;
      checks++; if (hwdata !== 32'h1111_1111) begin errors++; $display("FAIL release_hwdata got %h exp 11111111", hwdata); end
      tick();
   endtask

   task automatic test_reset_mid_read();
      valid = 1'b1; addr = 32'h80; wr = 1'b0;
      tick();
      valid = 1'b0; hrdata = 32'h5555_AAAA; rstn = 1'b0;
      #3;
      checks++; if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin errors++; $display("FAIL reset_mid_read got %b/%h exp 0/0", rd_valid, rd_data); end
      tick();
      tick();
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_after got %b exp 0", rd_valid); end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      hready = 1'b1; hresp = 1'b0;
      valid = 1'b1; addr = 32'h20; wr = 1'b1; wdata = 32'hDEAD_BEEF;
      #3;
      checks++; if (haddr !== 32'h20 || hwrite !== 1'b1) begin errors++; $display("FAIL b2b_wr_addr got %h/%b exp 20/1", haddr, hwrite); end
      tick();
      addr = 32'h24; wr = 1'b0; wdata = 32'h0;
      #3;
      checks++; if (haddr !== 32'h24 || hwrite !== 1'b0 || hwdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_rd_addr got %h/%b/%h exp 24/0/deadbeef", haddr, hwrite, hwdata); end
      tick();
      valid = 1'b0; hrdata = 32'hCAFE_BABE;
      #3;
      checks++; if (rd_valid !== (RL == 0)) begin errors++; $display("FAIL b2b_rd_valid0 got %b exp %b", rd_valid, RL == 0); end
      checks++; if (rd_data !== ((RL == 0) ? 32'hCAFE_BABE : 32'h0)) begin errors++; $display("FAIL b2b_rd_data0 got %h", rd_data); end
      tick();
      hrdata = 32'h0;
      #3;
      checks++; if (rd_valid !== (RL == 1) || rd_data !== ((RL == 1) ? 32'hCAFE_BABE : 32'h0)) begin errors++; $display("FAIL b2b_rd_lat1 got %b/%h", rd_valid, rd_data); end
      tick();
   endtask

   task automatic test_wait_state();
      valid = 1'b1; addr = 32'h28; wr = 1'b1; wdata = 32'hFEED_FACE;
      tick();
      addr = 32'h2C; wr = 1'b0;
      tick();
      addr = 32'h30; wr = 1'b1; wdata = 32'hFEE8_788A; hready = 1'b0; hrdata = 32'hBABE_FACE;
      #3;
      checks++; if (rd_valid !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL stall_rv_rdy got %b/%b exp 0/0", rd_valid, ready); end
      checks++; if (haddr !== 32'h30 || htrans !== 2'b10) begin errors++; $display("FAIL stall_haddr got %h/%h exp 30/2", haddr, htrans); end
      tick();
      hready = 1'b1;
      #3;
      eval();
      checks++; if (ready !== 1'b1 || haddr !== 32'h30) begin errors++; $display("FAIL stall_release got %b/%h exp 1/30", ready, haddr); end
      checks++; if (rd_valid !== (RL == 0) || rd_valid !== e_rv || rd_data !== e_rd) begin errors++; $display("FAIL stall_rd got %b/%h exp %b/%h", rd_valid, rd_data, e_rv, e_rd); end
      tick();
      valid = 1'b0;
   endtask

   task automatic test_idle();
      for (int i = 0; i < 3; i++) begin
         #3;
         eval();
         checks++; if (htrans !== 2'b00 || rd_valid !== e_rv || rd_data !== e_rd) begin errors++; $display("FAIL idle_%0d got %h/%b/%h exp 0/%b/%h", i, htrans, rd_valid, rd_data, e_rv, e_rd); end
         checks++; if (hwdata !== 32'hFEE8_788A) begin errors++; $display("FAIL idle_hwdata_%0d got %h exp fee8788a", i, hwdata); end
         tick();
      end
   endtask

   task automatic test_error();
      valid = 1'b1; addr = 32'h40; wr = 1'b0; hready = 1'b1; hresp = 1'b0;
      tick();
      addr = 32'h44; wr = 1'b1; wdata = 32'h1234_5678; hresp = 1'b1; hready = 1'b0; hrdata = 32'h9999_9999;
      #3;
      checks++; if (htrans !== 2'b00 || ready !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL err_c1 got %h/%b/%b exp 0/0/0", htrans, ready, rd_valid); end
      tick();
      hready = 1'b1;
      #3;
      checks++; if (htrans !== 2'b10 || haddr !== 32'h44 || ready !== 1'b1) begin errors++; $display("FAIL err_c2_reissue got %h/%h/%b exp 2/44/1", htrans, haddr, ready); end
      checks++; if (rd_valid !== (RL == 0) || rd_data !== 32'h0) begin errors++; $display("FAIL err_c2_rd got %b/%h exp %b/0", rd_valid, rd_data, RL == 0); end
      tick();
      valid = 1'b0; hresp = 1'b0;
      #3;
      checks++; if (rd_valid !== (RL == 1) || rd_data !== 32'h0 || hwdata !== 32'h1234_5678) begin errors++; $display("FAIL err_after got %b/%h/%h exp %b/0/12345678", rd_valid, rd_data, hwdata, RL == 1); end
      tick();
   endtask

   task automatic test_random();
      int err_state = 0;
      int rerr = 0;
      logic acc;
      acc = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (acc || !valid) begin
            valid = ($urandom_range(3) != 0);
            addr  = $urandom;
            wr    = $urandom_range(1);
            wdata = $urandom;
         end
         hrdata = $urandom;
         if (err_state == 1) begin
            hresp = 1'b1; hready = 1'b1; err_state = 0;
         end else if (dq.size() > 0 && $urandom_range(9) == 0) begin
            hresp = 1'b1; hready = 1'b0; err_state = 1;
         end else begin
            hresp = 1'b0; hready = ($urandom_range(3) != 0);
         end
         #3;
         eval();
         checks++;
         if (htrans !== e_trans || haddr !== e_haddr || hwrite !== e_hwrite || ready !== e_ready ||
             hwdata !== m_hwdata || rd_valid !== e_rv || rd_data !== e_rd) begin
            errors++;
            rerr++;
            if (rerr <= 5)
               $display("FAIL random_%0d got tr=%h a=%h w=%b rdy=%b wd=%h rv=%b rd=%h exp tr=%h a=%h w=%b rdy=%b wd=%h rv=%b rd=%h",
                        i, htrans, haddr, hwrite, ready, hwdata, rd_valid, rd_data,
                        e_trans, e_haddr, e_hwrite, e_ready, m_hwdata, e_rv, e_rd);
         end
         acc = valid && hready;
         tick();
      end
      hresp = 1'b0; hready = 1'b1; valid = 1'b0;
      tick();
   endtask

   initial begin
      rstn = 1'b0; valid = 1'b0; addr = '0; wr = 1'b0; wdata = '0;
      hready = 1'b1; hresp = 1'b0; hrdata = '0;
      model_clear();
      test_reset();
      test_reset_mid_read();
      test_back_to_back();
      test_wait_state();
      test_idle();
      test_error();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
